// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: per-level widths, sign/zero
// extension bit and the layout of the flattened all-levels data bus.
package adder_tree_pkg;

  localparam int unsigned MAX_LEVELS = 6;

  function automatic int unsigned lvl_width(input int unsigned width, input int unsigned lvl);
    return width + lvl;
  endfunction

  // x is the operand MSB; returns the bit prepended before each pairwise add
  function automatic logic ext(input logic x, input logic signed_mode);
    return signed_mode & x;
  endfunction

  // Level lvl occupies (N >> lvl) * (width + lvl) bits starting at this offset
  function automatic int unsigned lvl_offset(input int unsigned width,
                                             input int unsigned levels,
                                             input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < lvl; k++) begin
      off += ((32'd1 << levels) >> k) * lvl_width(width, k);
    end
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One tree level: PAIRS full-precision pairwise adders feeding an output
// register with its own valid bit and skid-free ready (empty stage always loads).
module adder_tree_stage
  import adder_tree_pkg::*;
#(
  parameter int unsigned IN_W   = 24,
  parameter int unsigned PAIRS  = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*PAIRS*IN_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAIRS*(IN_W+1)-1:0] out_data
);

  localparam int unsigned OUT_W = IN_W + 1;

  logic                   r_valid;
  logic [PAIRS*OUT_W-1:0] r_data;
  logic [PAIRS*OUT_W-1:0] w_sum;
  logic [IN_W-1:0]        w_a;
  logic [IN_W-1:0]        w_b;

  always_comb begin
    w_sum = '0;
    w_a   = '0;
    w_b   = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      w_a = in_data[(2*p)*IN_W +: IN_W];
      w_b = in_data[(2*p+1)*IN_W +: IN_W];
      w_sum[p*OUT_W +: OUT_W] = {ext(w_a[IN_W-1], SIGNED), w_a}
                              + {ext(w_b[IN_W-1], SIGNED), w_b};
    end
  end

  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= w_sum;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined, back-pressurable binary adder tree: 2**LEVELS operands of
// WIDTH bits reduced to one WIDTH+LEVELS bit sum, one register per level.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned LEVELS    = 3,
  parameter bit          SIGNED    = 1'b0,
  parameter bit          REG_INPUT = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(1<<LEVELS)*WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH+LEVELS-1:0]        out_sum
);

  localparam int unsigned N     = 1 << LEVELS;
  localparam int unsigned BUS_W = lvl_offset(WIDTH, LEVELS, LEVELS + 1);

  // All levels packed back to back: level 0 = operands, level LEVELS = final sum
  logic [BUS_W-1:0] w_bus;
  logic [LEVELS:0]  w_valid;
  logic [LEVELS:0]  w_ready;
  logic             w_in_ready;

  if (REG_INPUT) begin : g_capture
    logic             r_valid;
    logic [N*WIDTH-1:0] r_data;

    assign w_in_ready = !r_valid || w_ready[0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_in_ready) begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_data <= in_data;
        end
      end
    end

    assign w_valid[0]          = r_valid;
    assign w_bus[0 +: N*WIDTH] = r_data;
  end else begin : g_direct
    assign w_in_ready          = w_ready[0];
    assign w_valid[0]          = in_valid;
    assign w_bus[0 +: N*WIDTH] = in_data;
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_level
    localparam int unsigned IN_W  = lvl_width(WIDTH, l - 1);
    localparam int unsigned PAIRS = N >> l;

    adder_tree_stage #(
      .IN_W  (IN_W),
      .PAIRS (PAIRS),
      .SIGNED(SIGNED)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (w_valid[l-1]),
      .in_ready (w_ready[l-1]),
      .in_data  (w_bus[lvl_offset(WIDTH, LEVELS, l-1) +: 2*PAIRS*IN_W]),
      .out_valid(w_valid[l]),
      .out_ready(w_ready[l]),
      .out_data (w_bus[lvl_offset(WIDTH, LEVELS, l) +: PAIRS*(IN_W+1)])
    );
  end

  assign w_ready[LEVELS] = out_ready;
  assign in_ready        = w_in_ready || flush;
  assign out_valid       = w_valid[LEVELS];
  assign out_sum         = w_bus[lvl_offset(WIDTH, LEVELS, LEVELS) +: WIDTH+LEVELS];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: unsigned default-config DUT plus a signed 8-bit
// DUT without input register, both checked against an arithmetic scoreboard.
module tb_adder_tree_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         d_flush = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b1;
  logic [191:0] d_in_data = '0;
  logic         d_in_ready, d_out_valid;
  logic [26:0]  d_out_sum;

  logic         s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [63:0]  s_in_data = '0;
  logic         s_in_ready, s_out_valid;
  logic [10:0]  s_out_sum;

  adder_tree_pipe #(.WIDTH(24), .LEVELS(3), .SIGNED(1'b0), .REG_INPUT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(d_flush), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .in_data(d_in_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_sum(d_out_sum));

  adder_tree_pipe #(.WIDTH(8), .LEVELS(3), .SIGNED(1'b1), .REG_INPUT(1'b0)) u_sdut (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_data(s_in_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_sum(s_out_sum));

  int n_checks = 0, n_errors = 0;
  int d_acc = 0, d_del = 0, s_acc = 0, s_del = 0;
  longint d_q[$];
  longint s_q[$];

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference sums straight from the operand values
  function automatic longint model_d(input logic [191:0] v);
    longint s = 0;
    for (int j = 0; j < 8; j++) s += longint'(v[j*24 +: 24]);
    return s;
  endfunction

  function automatic longint model_s(input logic [63:0] v);
    longint s = 0;
    for (int j = 0; j < 8; j++) s += longint'($signed(v[j*8 +: 8]));
    return s;
  endfunction

  function automatic logic [191:0] rand_vec(input int unsigned w);
    logic [191:0] v = '0;
    logic [31:0]  mask = (32'd1 << w) - 32'd1;
    logic [31:0]  op;
    for (int unsigned j = 0; j < 8; j++) begin
      case ($urandom_range(0, 4))
        0:       op = '0;
        1:       op = mask;
        2:       op = 32'd1 << (w - 1);
        default: op = $urandom() & mask;
      endcase
      v |= 192'(op) << (j * w);
    end
    return v;
  endfunction

  logic        d_pv = 1'b0, d_pr = 1'b0, d_pf = 1'b0;
  logic [26:0] d_ps = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      d_q.delete();
      chk("d_reset_valid", longint'(d_out_valid), 0);
      chk("d_reset_sum", longint'(d_out_sum), 0);
      d_pv = 1'b0;
    end else begin
      if (d_pv && !d_pr && !d_pf) begin
        chk("d_stall_valid", longint'(d_out_valid), 1);
        chk("d_stall_sum", longint'(d_out_sum), longint'(d_ps));
      end
      if (d_out_valid && d_out_ready) begin
        d_del++;
        if (d_q.size() == 0) chk("d_spurious_out", 1, 0);
        else chk("d_sum", longint'(d_out_sum), d_q.pop_front());
      end
      if (d_flush) d_q.delete();
      else if (d_in_valid && d_in_ready) begin
        d_acc++;
        d_q.push_back(model_d(d_in_data));
      end
      d_pv = d_out_valid; d_pr = d_out_ready; d_pf = d_flush; d_ps = d_out_sum;
    end
  end

  logic        s_pv = 1'b0, s_pr = 1'b0, s_pf = 1'b0;
  logic [10:0] s_ps = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_q.delete();
      chk("s_reset_valid", longint'(s_out_valid), 0);
      chk("s_reset_sum", longint'(s_out_sum), 0);
      s_pv = 1'b0;
    end else begin
      if (s_pv && !s_pr && !s_pf) begin
        chk("s_stall_valid", longint'(s_out_valid), 1);
        chk("s_stall_sum", longint'(s_out_sum), longint'(s_ps));
      end
      if (s_out_valid && s_out_ready) begin
        s_del++;
        if (s_q.size() == 0) chk("s_spurious_out", 1, 0);
        else chk("s_sum", longint'($signed(s_out_sum)), s_q.pop_front());
      end
      if (s_flush) s_q.delete();
      else if (s_in_valid && s_in_ready) begin
        s_acc++;
        s_q.push_back(model_s(s_in_data));
      end
      s_pv = s_out_valid; s_pr = s_out_ready; s_pf = s_flush; s_ps = s_out_sum;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge
  task automatic send(input bit sgn, input logic [191:0] vec);
    bit ok = 1'b0;
    if (sgn) begin s_in_data = vec[63:0]; s_in_valid = 1'b1; end
    else begin d_in_data = vec; d_in_valid = 1'b1; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = sgn ? s_in_ready : d_in_ready;
      if (ok) break;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    if (sgn) s_in_valid = 1'b0; else d_in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit sgn, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sgn ? s_out_valid : d_out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt, a0, l0;
    bit dh, sh;
    logic [191:0] v;

    #2 rst_n = 1'b0;
    d_in_valid = 1'b1; s_in_valid = 1'b1; d_in_data = '1; s_in_data = '1;
    repeat (3) @(negedge clk);
    tick();
    d_in_valid = 1'b0; s_in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_d", longint'(d_in_ready), 1);
    chk("rst_in_ready_s", longint'(s_in_ready), 1);
    tick();

    send(1'b0, '1);
    wait_out(1'b0, lat);
    chk("d_latency", lat, 4);
    chk("d_all_ones", longint'(d_out_sum), longint'(27'h7FFFFF8));
    tick();

    send(1'b1, 192'(64'h7F7F7F7F_80808080));
    wait_out(1'b1, lat);
    chk("s_latency", lat, 3);
    chk("s_mixed", longint'(s_out_sum), longint'(11'h7FC));
    tick();
    send(1'b1, 192'(64'h80808080_80808080));
    wait_out(1'b1, lat);
    chk("s_all_min", longint'(s_out_sum), longint'(11'h400));
    tick();

    // Ordered stream under a 1-in-3 out_ready duty cycle
    l0 = d_del;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          for (int j = 0; j < 8; j++) v[j*24 +: 24] = 24'(k + j);
          send(1'b0, v);
        end
      end
      begin
        for (int c = 0; c < 120; c++) begin
          d_out_ready = (c % 3 == 2);
          tick();
        end
      end
    join
    d_out_ready = 1'b1;
    repeat (8) tick();
    chk("stream_delivered", d_del - l0, 20);
    chk("stream_drained", d_q.size(), 0);

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      dh = d_in_valid && !d_in_ready && !d_flush;
      sh = s_in_valid && !s_in_ready && !s_flush;
      tick();
      if (!dh) begin d_in_valid = ($urandom_range(0, 3) != 0); d_in_data = rand_vec(24); end
      if (!sh) begin s_in_valid = ($urandom_range(0, 3) != 0); s_in_data = rand_vec(8)[63:0]; end
      d_out_ready = ($urandom_range(0, 2) != 0);
      s_out_ready = ($urandom_range(0, 2) != 0);
      d_flush = ($urandom_range(0, 60) == 0);
      s_flush = ($urandom_range(0, 60) == 0);
    end
    d_flush = 1'b0; s_flush = 1'b0; d_in_valid = 1'b0; s_in_valid = 1'b0;
    d_out_ready = 1'b1; s_out_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained_d", d_q.size(), 0);
    chk("rand_drained_s", s_q.size(), 0);

    // Capacity is one vector per stage: the 5th offer sees in_ready low
    d_out_ready = 1'b0;
    d_in_valid = 1'b1;
    d_in_data = rand_vec(24);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!d_in_ready) break;
      cnt++;
      tick();
      d_in_data = rand_vec(24);
    end
    chk("fill_accepts", cnt, 4);
    tick();
    a0 = d_acc; l0 = d_del;
    d_out_ready = 1'b1;
    @(negedge clk);
    chk("pulse_in_ready", longint'(d_in_ready), 1);
    tick();
    d_out_ready = 1'b0;
    @(negedge clk);
    chk("pulse_one_out", d_del - l0, 1);
    chk("pulse_one_acc", d_acc - a0, 1);
    chk("refull_in_ready", longint'(d_in_ready), 0);

    tick();
    d_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", longint'(d_in_ready), 1);
    tick();
    d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b1;
    l0 = d_del;
    @(negedge clk);
    chk("flush_out_valid", longint'(d_out_valid), 0);
    repeat (6) @(negedge clk);
    chk("flush_none_emerge", d_del - l0, 0);

    tick();
    for (int k = 0; k < 3; k++) send(1'b0, rand_vec(24));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    rst_n = 1'b1;
    l0 = d_del;
    repeat (6) @(negedge clk);
    chk("rst_none_emerge", d_del - l0, 0);
    chk("rst_out_valid", longint'(d_out_valid), 0);
    tick();
    send(1'b0, rand_vec(24));
    wait_out(1'b0, lat);
    chk("post_rst_latency", lat, 4);
    repeat (4) tick();
    chk("final_drained", d_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
